regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised register file for the RISC-V cores, replacing the fixed two-read/one-write file. It provides NR combinational read ports with write-through bypass, a hardwired zero register, and a clear-on-reset array. A per-register scoreboard (busy bits) lets a pipelined datapath reserve a destination at issue and detect read-after-write hazards until writeback. It sits between decode (read addresses, reservation) and writeback (write port).

## Interface
- W, 32: data width in bits.
- DEPTH, 32: number of registers; power of two, at least 2.
- AW, $clog2(DEPTH): address width (derived; do not override).
- NR, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 means register 0 reads 0, ignores writes and is never busy. 0 means register 0 is ordinary.

- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- RA  in  NR*AW  read addresses; port i uses bits [i*AW +: AW].
- RD  out  NR*W  read data; port i uses bits [i*W +: W].
- RBusy  out  NR  per-port hazard flag; 1 means the addressed register has a pending producer.
- WE  in  1  write enable.
- WA  in  AW  write address.
- WD  in  W  write data.
- Rsv  in  1  reserve-destination strobe.
- RsvA  in  AW  address to reserve.
- BusyAny  out  1  OR of all busy bits.

## Operation
- Storage: DEPTH×W array and a DEPTH-bit busy vector.
- Reset:
  - Rst_n low immediately clears every register and every busy bit.
  - While reset is asserted: RD = 0, RBusy = 0, BusyAny = 0.
  - WE and Rsv are ignored while Rst_n is low.
  - Release is sampled at the next rising edge.
- Write: at the rising edge with WE=1, array[WA] ← WD and busy[WA] ← 0.
  - Skipped when ZERO_REG=1 and WA=0.
- Reserve: at the rising edge with Rsv=1, busy[RsvA] ← 1.
  - Skipped when ZERO_REG=1 and RsvA=0.
- Same-edge write and reserve to the same address: the data is written and busy ends at 1 (the new producer wins).
- Same-edge write and reserve to different addresses: both take effect independently.
- Read port i (combinational), evaluated in priority order:
  1. ZERO_REG=1 and RA_i=0 → RD_i = 0, RBusy_i = 0.
  2. WE=1 and WA=RA_i (bypass) → RD_i = WD, RBusy_i = 0.
  3. Otherwise → RD_i = array[RA_i], RBusy_i = busy[RA_i].
- Multiple read ports addressing the same register return identical values.
- Reserving an already-busy register leaves it busy; no counting, and the last producer's write clears it.
- Writing a register that is not busy is legal and leaves it not busy.
- BusyAny is combinational from the registered busy vector only, with no bypass.
- Out-of-range addresses are impossible (DEPTH = 2^AW).

## Timing
- Read latency: 0 cycles (combinational from RA, WE, WA, WD and state).
- Write latency: data is visible on RD in the same cycle via bypass, and from the array on the cycle after the edge.
- Reserve latency: RBusy and BusyAny rise in the cycle after the edge on which Rsv=1 was sampled.
- Busy clear: visible on RBusy in the same cycle WE is presented (bypass); BusyAny falls after the edge.
- Reset assertion mid-operation: a pending write or reserve in that cycle is lost; the array reads all-zero asynchronously.
- No handshake stalls: the block accepts one write and one reserve per cycle, unconditionally.

## Test plan
1. Reset clear: write 0xDEADBEEF to r5, then pulse Rst_n low between edges → RD for RA=5 reads 0 immediately; RBusy=0; BusyAny=0.
2. Zero register: WE=1, WA=0, WD=0x12345678, then Rsv=1, RsvA=0 → RA=0 reads 0, RBusy=0 and BusyAny=0 on every cycle.
3. Bypass: WE=1, WA=7, WD=0xA5A5A5A5 with RA port0=7 and port1=7 in the same cycle → both ports read 0xA5A5A5A5 before the edge and after it with WE=0.
4. Scoreboard lifecycle: Rsv r3 at edge 1 → RBusy(RA=3)=1 from cycle 2. Write r3=0x55 in cycle 4 → RBusy=0 and RD=0x55 in cycle 4. BusyAny falls in cycle 5.
5. Simultaneous write and reserve to r9 on one edge → next cycle r9 holds the written data and RBusy=1. A write to r9 on a later cycle clears it.
6. Parameter sweep with W=16, DEPTH=8, NR=4, ZERO_REG=0: write r0=0xBEEF → all four ports at RA=0 read 0xBEEF; reserve r0 → RBusy=4'b1111.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : NR-read / 1-write register file with write-through bypass,
//            optional hardwired zero register and per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int W        = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [NR*AW-1:0] RA,
    output logic [NR*W-1:0]  RD,
    output logic [NR-1:0]    RBusy,
    input  logic            WE,
    input  logic [AW-1:0]   WA,
    input  logic [W-1:0]    WD,
    input  logic            Rsv,
    input  logic [AW-1:0]   RsvA,
    output logic            BusyAny
);

    localparam bit c_zero = (ZERO_REG != 0);

    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_wr_en;
    logic             w_rsv_en;

    assign w_wr_en  = WE  && !(c_zero && (WA   == '0));
    assign w_rsv_en = Rsv && !(c_zero && (RsvA == '0));

    // Reserve is applied after the write clear so a same-edge producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[WA] = 1'b0;
        end
        if (w_rsv_en) begin
            w_busy_nxt[RsvA] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[WA] <= WD;
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [W-1:0]  w_rdata;
        logic          w_rbusy;

        assign w_ra = RA[gi*AW +: AW];

        // Reset gating keeps the bypass path quiet while Rst_n is low.
        always_comb begin
            w_rdata = '0;
            w_rbusy = 1'b0;
            if (Rst_n && !(c_zero && (w_ra == '0))) begin
                if (WE && (WA == w_ra)) begin
                    w_rdata = WD;
                end else begin
                    w_rdata = r_mem[w_ra];
                    w_rbusy = r_busy[w_ra];
                end
            end
        end

        assign RD[gi*W +: W] = w_rdata;
        assign RBusy[gi]     = w_rbusy;
    end

    assign BusyAny = |r_busy;

endmodule
`default_nettype wire
